// File: rtl/spi_rx_fifo.sv
// SPI mode-0 receive deserialiser feeding a word FIFO drained by single-cycle POP strobes (optional SPI_RX_OVERRUN_EN flag).
// Latency: SCK pin to sample 3 PCLK, last sample to push 1 PCLK, POP to read_data 1 PCLK.
// Backpressure: none toward SPI; a push into a full FIFO without a same-cycle POP is dropped.
module spi_rx_fifo #(
    parameter int DWIDTH        = 8,
    parameter int FIFO_DEPTH    = 8,
    parameter int counter_width = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                     PCLK,
    input  logic                     PRESETn,
    input  logic                     SPI_SCK,
    input  logic                     SPI_MISO,
    input  logic                     SPI_CS_N,
    input  logic                     POP,
    output logic [DWIDTH-1:0]        read_data,
    output logic                     EMPTY,
    output logic                     FULL,
    output logic [counter_width-1:0] cnt
`ifdef SPI_RX_OVERRUN_EN
    ,
    output logic                     OVERRUN,
    input  logic                     CLR_OVR
`endif
);

    localparam int BW = $clog2(DWIDTH);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [BW-1:0]            LP_LAST  = BW'(DWIDTH - 1);
    localparam logic [counter_width-1:0] LP_DEPTH = counter_width'(FIFO_DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_PUSH} state_t;

    logic [1:0]              r_sck_sync, r_miso_sync, r_cs_sync;
    logic                    r_sck_d;
    state_t                  r_state, w_state_nxt;
    logic [DWIDTH-1:0]       r_shift;
    logic [BW-1:0]           r_bitcnt;
    logic [DWIDTH-1:0]       r_mem [FIFO_DEPTH];
    logic [PW-1:0]           r_wr_ptr, r_rd_ptr;
    logic [counter_width-1:0] r_cnt;
    logic [DWIDTH-1:0]       r_rdata;
    logic                    w_sck_rise, w_miso, w_cs_n;
    logic                    w_push, w_push_ok, w_pop_ok;

    // CS_N synchroniser resets to the inactive level so IDLE waits for a genuine low.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_sck_sync  <= 2'b00;
            r_miso_sync <= 2'b00;
            r_cs_sync   <= 2'b11;
            r_sck_d     <= 1'b0;
        end else begin
            r_sck_sync  <= {r_sck_sync[0], SPI_SCK};
            r_miso_sync <= {r_miso_sync[0], SPI_MISO};
            r_cs_sync   <= {r_cs_sync[0], SPI_CS_N};
            r_sck_d     <= r_sck_sync[1];
        end
    end

    assign w_sck_rise = r_sck_sync[1] & ~r_sck_d;
    assign w_miso     = r_miso_sync[1];
    assign w_cs_n     = r_cs_sync[1];

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        case (r_state)
            ST_IDLE:  if (!w_cs_n) w_state_nxt = ST_SHIFT;
            ST_SHIFT: begin
                if (w_cs_n)                                 w_state_nxt = ST_IDLE;
                else if (w_sck_rise && r_bitcnt == LP_LAST) w_state_nxt = ST_PUSH;
            end
            ST_PUSH: begin
                w_push      = 1'b1;
                w_state_nxt = w_cs_n ? ST_IDLE : ST_SHIFT;
            end
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_shift  <= '0;
            r_bitcnt <= '0;
        end else begin
            case (r_state)
                ST_SHIFT: if (!w_cs_n && w_sck_rise) begin
                    r_shift  <= {r_shift[DWIDTH-2:0], w_miso};
                    r_bitcnt <= r_bitcnt + 1'b1;
                end
                ST_PUSH:  r_bitcnt <= '0;
                default: begin
                    r_shift  <= '0;
                    r_bitcnt <= '0;
                end
            endcase
        end
    end

    // When full, a same-cycle pop frees the slot; the pop reads the old word before it is overwritten.
    assign w_pop_ok  = POP & (r_cnt != '0);
    assign w_push_ok = w_push & ((r_cnt < LP_DEPTH) | POP);

    always_ff @(posedge PCLK) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= r_shift;
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            r_rdata  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok) begin
                r_rdata  <= r_mem[r_rd_ptr];
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push_ok && !w_pop_ok)      r_cnt <= r_cnt + 1'b1;
            else if (w_pop_ok && !w_push_ok) r_cnt <= r_cnt - 1'b1;
        end
    end

`ifdef SPI_RX_OVERRUN_EN
    logic r_ovr;
    logic w_drop;
    assign w_drop = w_push & ~w_push_ok;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn)     r_ovr <= 1'b0;
        else if (w_drop)  r_ovr <= 1'b1;
        else if (CLR_OVR) r_ovr <= 1'b0;
    end

    assign OVERRUN = r_ovr;
`endif

    assign read_data = r_rdata;
    assign cnt       = r_cnt;
    assign EMPTY     = (r_cnt == '0);
    assign FULL      = (r_cnt == LP_DEPTH);

endmodule

// File: tb/tb_spi_rx_fifo.sv
// Directed bench for spi_rx_fifo: serial frames in, POP strobes out, hand-computed expectations.
module tb_spi_rx_fifo;

    logic       PCLK;
    logic       PRESETn;
    logic       SPI_SCK;
    logic       SPI_MISO;
    logic       SPI_CS_N;
    logic       POP;
    logic [7:0] read_data;
    logic       EMPTY;
    logic       FULL;
    logic [3:0] cnt;
`ifdef SPI_RX_OVERRUN_EN
    logic       OVERRUN;
    logic       CLR_OVR;
`endif

    int n_checks = 0;
    int n_errors = 0;

    spi_rx_fifo #(.DWIDTH(8), .FIFO_DEPTH(8)) dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .SPI_SCK   (SPI_SCK),
        .SPI_MISO  (SPI_MISO),
        .SPI_CS_N  (SPI_CS_N),
        .POP       (POP),
        .read_data (read_data),
        .EMPTY     (EMPTY),
        .FULL      (FULL),
        .cnt       (cnt)
`ifdef SPI_RX_OVERRUN_EN
        ,
        .OVERRUN   (OVERRUN),
        .CLR_OVR   (CLR_OVR)
`endif
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    // One word MSB-first, SCK low/high phases of 4 PCLK; optionally POP in the exact PUSH cycle.
    task automatic send_word(input logic [7:0] w, input int nbits, input bit pop_on_push);
        for (int i = 0; i < nbits; i++) begin
            SPI_MISO = w[7-i];
            tick(4);
            SPI_SCK = 1'b1;
            if (pop_on_push && i == nbits - 1) begin
                tick(3);
                POP = 1'b1;
                tick(1);
                POP = 1'b0;
            end else begin
                tick(4);
            end
            SPI_SCK = 1'b0;
        end
    endtask

    task automatic frame_begin();
        SPI_CS_N = 1'b0;
        tick(4);
    endtask

    task automatic frame_end();
        tick(4);
        SPI_CS_N = 1'b1;
        tick(6);
    endtask

    task automatic pop_chk(input string tag, input logic [7:0] exp);
        POP = 1'b1;
        tick(1);
        POP = 1'b0;
        @(negedge PCLK);
        chk(tag, 32'(read_data), 32'(exp));
    endtask

    initial begin
        logic [7:0] v;
        PRESETn  = 1'b0;
        SPI_SCK  = 1'b0;
        SPI_MISO = 1'b0;
        SPI_CS_N = 1'b1;
        POP      = 1'b0;
`ifdef SPI_RX_OVERRUN_EN
        CLR_OVR  = 1'b0;
`endif
        tick(3);
        @(negedge PCLK);
        chk("rst_cnt",   32'(cnt),       32'd0);
        chk("rst_empty", 32'(EMPTY),     32'd1);
        chk("rst_full",  32'(FULL),      32'd0);
        chk("rst_rdata", 32'(read_data), 32'd0);
`ifdef SPI_RX_OVERRUN_EN
        chk("rst_ovr",   32'(OVERRUN),   32'd0);
`endif
        tick(1);
        PRESETn = 1'b1;
        tick(2);

        // Single frame 0xA5
        frame_begin();
        send_word(8'hA5, 8, 1'b0);
        frame_end();
        @(negedge PCLK);
        chk("t1_cnt",   32'(cnt),   32'd1);
        chk("t1_empty", 32'(EMPTY), 32'd0);
        pop_chk("t1_rd", 8'hA5);
        chk("t1_cnt_after",   32'(cnt),   32'd0);
        chk("t1_empty_after", 32'(EMPTY), 32'd1);

        // Nine words into an 8-deep FIFO: 0x09 dropped
        frame_begin();
        for (int i = 1; i <= 9; i++) send_word(8'(i), 8, 1'b0);
        frame_end();
        @(negedge PCLK);
        chk("t2_full", 32'(FULL), 32'd1);
        chk("t2_cnt",  32'(cnt),  32'd8);
`ifdef SPI_RX_OVERRUN_EN
        chk("t2_ovr",  32'(OVERRUN), 32'd1);
`endif
        for (int i = 1; i <= 8; i++) pop_chk("t2_rd", 8'(i));
        chk("t2_empty", 32'(EMPTY), 32'd1);
`ifdef SPI_RX_OVERRUN_EN
        CLR_OVR = 1'b1;
        tick(1);
        CLR_OVR = 1'b0;
        @(negedge PCLK);
        chk("t2_ovr_clr", 32'(OVERRUN), 32'd0);
`endif

        // Full FIFO, POP coincides with PUSH of 0x19
        frame_begin();
        for (int i = 0; i < 8; i++) send_word(8'h11 + 8'(i), 8, 1'b0);
        frame_end();
        @(negedge PCLK);
        chk("t3_full", 32'(FULL), 32'd1);
        frame_begin();
        send_word(8'h19, 8, 1'b1);
        frame_end();
        @(negedge PCLK);
        chk("t3_rd_first", 32'(read_data), 32'h11);
        chk("t3_cnt",      32'(cnt),       32'd8);
`ifdef SPI_RX_OVERRUN_EN
        chk("t3_ovr",      32'(OVERRUN),   32'd0);
`endif
        for (int i = 0; i < 8; i++) begin
            v = 8'h12 + 8'(i);
            pop_chk("t3_rd", v);
        end
        chk("t3_empty", 32'(EMPTY), 32'd1);

        // Aborted partial word, then a clean 0x3C
        frame_begin();
        send_word(8'hFF, 5, 1'b0);
        SPI_CS_N = 1'b1;
        tick(6);
        frame_begin();
        send_word(8'h3C, 8, 1'b0);
        frame_end();
        @(negedge PCLK);
        chk("t4_cnt", 32'(cnt), 32'd1);
        pop_chk("t4_rd", 8'h3C);

        // Reset mid-frame with three words stored
        frame_begin();
        send_word(8'h31, 8, 1'b0);
        send_word(8'h32, 8, 1'b0);
        send_word(8'h33, 8, 1'b0);
        frame_end();
        @(negedge PCLK);
        chk("t5_cnt_pre", 32'(cnt), 32'd3);
        frame_begin();
        send_word(8'h55, 3, 1'b0);
        PRESETn = 1'b0;
        tick(2);
        @(negedge PCLK);
        chk("t5_cnt",   32'(cnt),       32'd0);
        chk("t5_empty", 32'(EMPTY),     32'd1);
        chk("t5_rdata", 32'(read_data), 32'd0);
        tick(1);
        PRESETn = 1'b1;
        tick(4);
        send_word(8'h7E, 8, 1'b0);
        frame_end();
        @(negedge PCLK);
        chk("t5_cnt_post", 32'(cnt), 32'd1);
        pop_chk("t5_rd", 8'h7E);

        // POP on empty
        pop_chk("t6_rd_hold", 8'h7E);
        chk("t6_cnt",   32'(cnt),   32'd0);
        chk("t6_empty", 32'(EMPTY), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/spi_rx_fifo.md
# spi_rx_fifo

- Receive path of the SPI block.
- Samples the MISO line under SPI_SCK/SPI_CS_N, deserialises DWIDTH-bit words MSB-first (SPI mode 0), and buffers them in a FIFO.
- The APB register block drains the FIFO with single-cycle POP strobes.
- Mirrors the transmit FIFO on the other side of the shifter. All logic runs in the PCLK domain.

## Interface

Parameters:
- DWIDTH, 8: word width in bits; also the number of SCK edges per word.
- FIFO_DEPTH, 8: number of words; power of two, at least 2.
- counter_width, $clog2(FIFO_DEPTH+1): width of cnt.

Ports:
- PCLK  in  1  system clock; the only clock.
- PRESETn  in  1  reset, asynchronous, active-low.
- SPI_SCK  in  1  serial clock, asynchronous to PCLK.
- SPI_MISO  in  1  serial data, asynchronous to PCLK.
- SPI_CS_N  in  1  frame select, active-low, asynchronous to PCLK.
- POP  in  1  read strobe from the APB side; one pulse pops one word.
- read_data  out  DWIDTH  word popped by the last accepted POP; reset 0.
- EMPTY  out  1  cnt == 0; reset 1.
- FULL  out  1  cnt == FIFO_DEPTH; reset 0.
- cnt  out  counter_width  words stored; reset 0.
- OVERRUN  out  1  sticky overrun flag; reset 0. Present only with the macro (see Configuration).
- CLR_OVR  in  1  clears OVERRUN. Present only with the macro (see Configuration).

## Operation

Input synchronisation:
- SPI_SCK, SPI_MISO and SPI_CS_N each pass through a 2-flop synchroniser.
- A rising SCK edge is detected from the synchronised SCK and its one-cycle-delayed copy.

Deserialiser state machine, with a bit counter of $clog2(DWIDTH) bits:
- IDLE: shift register and bit counter held at 0. Moves to SHIFT when synchronised CS_N is low.
- SHIFT: on each detected rising SCK edge, shift in MISO at bit 0 (MSB-first) and increment the bit counter.
  - When the sample taken at bit counter == DWIDTH-1 completes, move to PUSH.
  - If synchronised CS_N goes high, move to IDLE and discard the partial word; no push occurs.
- PUSH: asserts the internal push for exactly one cycle and clears the bit counter.
  - Moves to SHIFT if CS_N is still low (back-to-back words); otherwise moves to IDLE.

FIFO:
- Write pointer and read pointer, each $clog2(FIFO_DEPTH) bits. Both wrap from FIFO_DEPTH-1 to 0.
- Push is accepted when cnt < FIFO_DEPTH, or when POP is asserted in the same cycle.
- A rejected push drops the word; pointers and cnt are unchanged.
- POP when EMPTY is ignored: read_data and the pointers are unchanged.
- Accepted POP loads read_data with DATA[rd_ptr] and advances rd_ptr. read_data holds its value between pops.
- cnt update: +1 on accepted push without pop; -1 on accepted pop without push; unchanged when both are accepted in the same cycle.
- Simultaneous push and pop with cnt == 0: the push is written and the pop is ignored.
- EMPTY and FULL are decoded combinationally from cnt.

Reset:
- PRESETn low immediately clears state, pointers, cnt, read_data, the shift register and the synchronisers.
- Reset asserted mid-frame discards the word in progress.
- After release, a frame already under way is aligned from IDLE: the state machine enters SHIFT only once CS_N is seen low, and counts bits from 0.

## Timing

- Pin-to-detect latency: 3 PCLK cycles (2 synchroniser flops plus 1 edge-detect flop).
- SPI_SCK high and low phases must each be at least 3 PCLK periods. MISO must be stable 3 PCLK cycles around each rising SCK edge.
- Last bit sample to push: 1 cycle (PUSH state). cnt, EMPTY and FULL reflect the push on the following edge.
- POP to read_data valid: 1 cycle (registered). cnt decrements on the same edge.
- A word written by a push can be popped starting in the cycle after that push.

## Configuration

- SPI_RX_OVERRUN_EN defined:
  - OVERRUN and CLR_OVR exist.
  - OVERRUN sets on the cycle after any rejected push and stays set until CLR_OVR.
  - A rejected push together with CLR_OVR in the same cycle leaves OVERRUN set (set wins).
- SPI_RX_OVERRUN_EN not defined: both ports and the flag logic are absent. Dropped words are silent; all other behaviour is identical.

## Test plan

- Reset, then one frame of 0xA5 (DWIDTH=8) -> cnt=1, EMPTY=0; a POP gives read_data=0xA5 one cycle later, then cnt=0 and EMPTY=1.
- Nine back-to-back words under one CS_N low period (FIFO_DEPTH=8), values 0x01..0x09 -> FULL=1 and cnt=8; 0x09 is dropped and OVERRUN=1 (macro on); 8 pops return 0x01..0x08 in order.
- FIFO full, POP asserted in the same cycle as the PUSH of a new word -> push accepted, cnt stays 8, no overrun, pointers wrap correctly.
- CS_N deasserted after 5 of 8 bits, then a full frame 0x3C -> only 0x3C is stored; cnt=1.
- PRESETn pulsed mid-frame with 3 words stored -> cnt=0, EMPTY=1, read_data=0; the next complete frame 0x7E pops correctly.
- POP on empty FIFO -> read_data unchanged, cnt stays 0, EMPTY stays 1.
